reorder_commit_buffer: RTL and testbench
========================================

Name: reorder_commit_buffer

Overview:
- In-order retirement buffer (ROB) that sits after rename/dispatch and drives the commit interface back into the rename stage.
- Rename allocates one entry per instruction, carrying the destination arch register, the newly mapped physical register, and the previously mapped physical register.
- The execute/writeback side marks entries complete out of order.
- The block retires completed entries strictly in allocation order, one per cycle, and presents the superseded physical register for return to the free list.

Parameters:
ROB_ID_WIDTH, 4, log2 of entry count (16 entries)
ARCH_REG_NUM_WIDTH, `ARCH_REG_NUM_WIDTH, width of arch register number
PHYSICAL_REG_NUM_WIDTH, `PHYSICAL_REG_NUM_WIDTH, width of physical register number

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
alloc_valid  in  1  rename requests an entry this cycle
alloc_ready  out  1  entry available (=!rob_full)
alloc_has_write  in  1  instruction writes a destination register
alloc_arch_rd  in  ARCH_REG_NUM_WIDTH  destination arch register
alloc_new_phy  in  PHYSICAL_REG_NUM_WIDTH  newly allocated physical register
alloc_old_phy  in  PHYSICAL_REG_NUM_WIDTH  previous mapping of alloc_arch_rd
alloc_rob_id  out  ROB_ID_WIDTH  id given to the current allocation (= tail pointer)
complete_valid  in  1  execution finished for an entry
complete_rob_id  in  ROB_ID_WIDTH  id of the finished entry
commit_valid  out  1  one-cycle pulse per retired entry
commit_with_write  out  1  retired entry had a destination write
commited_wr_register  out  PHYSICAL_REG_NUM_WIDTH  old physical register to free
commit_arch_rd  out  ARCH_REG_NUM_WIDTH  arch register of the retired entry
commit_new_phy  out  PHYSICAL_REG_NUM_WIDTH  committed mapping of commit_arch_rd
commit_rob_id  out  ROB_ID_WIDTH  id of the retired entry
rob_count  out  ROB_ID_WIDTH+1  occupied entries
rob_empty  out  1  rob_count==0
rob_full  out  1  rob_count==2^ROB_ID_WIDTH

Behaviour:
- Reset (asynchronous, active-high): head=tail=0, count=0, all valid/done bits=0.
  - All commit_* outputs=0; alloc_rob_id=0; alloc_ready=1; rob_empty=1; rob_full=0.
  - Reset asserted mid-operation discards all entries with no commits emitted.
- Entry state: each entry is EMPTY (valid=0), PENDING (valid=1, done=0), or DONE (valid=1, done=1).
  - EMPTY->PENDING on allocate.
  - PENDING->DONE on complete.
  - DONE->EMPTY on retire.
- Allocate: alloc_fire = alloc_valid && alloc_ready.
  - On the edge, entry[tail] captures has_write, arch_rd, new_phy, old_phy with done=0.
  - tail increments mod 2^ROB_ID_WIDTH.
  - alloc_valid with alloc_ready=0 is ignored; no state change.
  - alloc_ready and the flags derive from registered count only. There is no same-cycle bypass from a retire, so a full ROB stays not-ready in the cycle a retire occurs.
- Complete: if complete_valid and entry[complete_rob_id] is valid, done is set on the edge.
  - Complete to an EMPTY entry or an already-DONE entry is ignored.
  - Completion order is unrestricted.
- Retire: retire_fire = entry[head].valid && entry[head].done, evaluated from registered state.
  - On the edge: entry[head].valid cleared, head increments mod 2^ROB_ID_WIDTH, and the commit_* outputs register the entry fields.
  - commit_valid is high for exactly the one following cycle; at most one retire per cycle.
- Latency: complete sampled at edge N -> done set at N -> commit_valid high in the cycle after edge N+1. Minimum allocate-to-commit is 3 edges.
- commit_with_write=0 forces commited_wr_register=0 and commit_new_phy=0. commit_arch_rd is still reported.
- When commit_valid=0, all commit_* data outputs hold 0.
- Count update per edge: +1 on alloc_fire only, -1 on retire_fire only, unchanged on both or neither. Count never exceeds 2^ROB_ID_WIDTH.
- Same-cycle complete to the head entry: done is set on that edge; retire occurs on the following edge, never in the same cycle.
- A complete_rob_id that equals the id being allocated in the same cycle is ignored, because that entry is still EMPTY in registered state.

Test Plan:
1. Assert reset for 2 cycles then release -> alloc_ready=1, rob_empty=1, rob_count=0, commit_valid=0, alloc_rob_id=0.
2. Allocate ids 0,1,2 (arch 3/4/5, new_phy 33/34/35, old_phy 3/4/5), then complete 2, 1, 0 on consecutive cycles -> no commit until id 0 completes; then commit_valid on 3 consecutive cycles with commit_rob_id 0,1,2 and commited_wr_register 3,4,5.
3. Allocate 16 entries with none completed -> rob_full=1, alloc_ready=0; a 17th alloc_valid is ignored, rob_count stays 16, and tail-dependent alloc_rob_id stays 0.
4. Steady stream of 20 alloc+complete operations -> alloc_rob_id wraps 15->0, and commits stay in order 0..15,0..3 with no gaps after pipeline fill.
5. Allocate with alloc_has_write=0 and old_phy=7, then complete -> commit_valid=1, commit_with_write=0, commited_wr_register=0.
6. 5 entries allocated, ids 0 and 1 DONE, reset pulsed mid-stream -> no commit_valid pulse; rob_count=0, rob_empty=1, and the next allocation gets id 0.

Source files
------------

// File: rtl/reorder_commit_buffer.sv
// In-order retirement buffer: rename allocates at the tail, execute marks entries done
// in any order, and one done entry per cycle retires from the head toward rename.
module reorder_commit_buffer #(
    parameter int ROB_ID_WIDTH           = 4,
    parameter int ARCH_REG_NUM_WIDTH     = 5,
    parameter int PHYSICAL_REG_NUM_WIDTH = 6
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              alloc_valid,
    output logic                              alloc_ready,
    input  logic                              alloc_has_write,
    input  logic [ARCH_REG_NUM_WIDTH-1:0]     alloc_arch_rd,
    input  logic [PHYSICAL_REG_NUM_WIDTH-1:0] alloc_new_phy,
    input  logic [PHYSICAL_REG_NUM_WIDTH-1:0] alloc_old_phy,
    output logic [ROB_ID_WIDTH-1:0]           alloc_rob_id,
    input  logic                              complete_valid,
    input  logic [ROB_ID_WIDTH-1:0]           complete_rob_id,
    output logic                              commit_valid,
    output logic                              commit_with_write,
    output logic [PHYSICAL_REG_NUM_WIDTH-1:0] commited_wr_register,
    output logic [ARCH_REG_NUM_WIDTH-1:0]     commit_arch_rd,
    output logic [PHYSICAL_REG_NUM_WIDTH-1:0] commit_new_phy,
    output logic [ROB_ID_WIDTH-1:0]           commit_rob_id,
    output logic [ROB_ID_WIDTH:0]             rob_count,
    output logic                              rob_empty,
    output logic                              rob_full
);

    localparam int DEPTH = 1 << ROB_ID_WIDTH;

    logic [ROB_ID_WIDTH-1:0] head_reg;
    logic [ROB_ID_WIDTH-1:0] tail_reg;
    logic [ROB_ID_WIDTH:0]   count_reg;
    logic [DEPTH-1:0]        valid_reg;
    logic [DEPTH-1:0]        done_reg;

    // Payload storage carries no reset: valid_reg alone decides whether a slot is live.
    logic                              has_write_mem [DEPTH];
    logic [ARCH_REG_NUM_WIDTH-1:0]     arch_rd_mem   [DEPTH];
    logic [PHYSICAL_REG_NUM_WIDTH-1:0] new_phy_mem   [DEPTH];
    logic [PHYSICAL_REG_NUM_WIDTH-1:0] old_phy_mem   [DEPTH];

    logic alloc_fire;
    logic retire_fire;

    assign rob_full     = (count_reg == (ROB_ID_WIDTH+1)'(DEPTH));
    assign rob_empty    = (count_reg == '0);
    assign rob_count    = count_reg;
    assign alloc_ready  = !rob_full;
    assign alloc_rob_id = tail_reg;
    assign alloc_fire   = alloc_valid && alloc_ready;
    assign retire_fire  = valid_reg[head_reg] && done_reg[head_reg];

    always_ff @(posedge clk) begin
        if (alloc_fire) begin
            has_write_mem[tail_reg] <= alloc_has_write;
            arch_rd_mem[tail_reg]   <= alloc_arch_rd;
            new_phy_mem[tail_reg]   <= alloc_new_phy;
            old_phy_mem[tail_reg]   <= alloc_old_phy;
        end
    end

    // A completion only lands on a slot that is already valid in registered state,
    // so a same-cycle complete to the slot being allocated is dropped.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    valid_reg[gi] <= 1'b0;
                    done_reg[gi]  <= 1'b0;
                end else if (alloc_fire && tail_reg == ROB_ID_WIDTH'(gi)) begin
                    valid_reg[gi] <= 1'b1;
                    done_reg[gi]  <= 1'b0;
                end else if (retire_fire && head_reg == ROB_ID_WIDTH'(gi)) begin
                    valid_reg[gi] <= 1'b0;
                    done_reg[gi]  <= 1'b0;
                end else if (complete_valid && complete_rob_id == ROB_ID_WIDTH'(gi)
                             && valid_reg[gi]) begin
                    done_reg[gi] <= 1'b1;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            if (alloc_fire) begin
                tail_reg <= tail_reg + 1'b1;
            end
            if (retire_fire) begin
                head_reg <= head_reg + 1'b1;
            end
            case ({alloc_fire, retire_fire})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Commit data is zero whenever no retire happened; register fields are zero
    // for entries without a destination write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            commit_valid         <= 1'b0;
            commit_with_write    <= 1'b0;
            commited_wr_register <= '0;
            commit_arch_rd       <= '0;
            commit_new_phy       <= '0;
            commit_rob_id        <= '0;
        end else if (retire_fire) begin
            commit_valid         <= 1'b1;
            commit_with_write    <= has_write_mem[head_reg];
            commited_wr_register <= has_write_mem[head_reg] ? old_phy_mem[head_reg] : '0;
            commit_arch_rd       <= arch_rd_mem[head_reg];
            commit_new_phy       <= has_write_mem[head_reg] ? new_phy_mem[head_reg] : '0;
            commit_rob_id        <= head_reg;
        end else begin
            commit_valid         <= 1'b0;
            commit_with_write    <= 1'b0;
            commited_wr_register <= '0;
            commit_arch_rd       <= '0;
            commit_new_phy       <= '0;
            commit_rob_id        <= '0;
        end
    end

endmodule

// File: tb/tb_reorder_commit_buffer.sv
// Directed bench for reorder_commit_buffer: allocation, out-of-order completion,
// in-order retirement, full/wrap behaviour and asynchronous reset.
module tb_reorder_commit_buffer;

    logic       clk = 1'b0;
    logic       reset;
    logic       alloc_valid;
    logic       alloc_ready;
    logic       alloc_has_write;
    logic [4:0] alloc_arch_rd;
    logic [5:0] alloc_new_phy;
    logic [5:0] alloc_old_phy;
    logic [3:0] alloc_rob_id;
    logic       complete_valid;
    logic [3:0] complete_rob_id;
    logic       commit_valid;
    logic       commit_with_write;
    logic [5:0] commited_wr_register;
    logic [4:0] commit_arch_rd;
    logic [5:0] commit_new_phy;
    logic [3:0] commit_rob_id;
    logic [4:0] rob_count;
    logic       rob_empty;
    logic       rob_full;

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    reorder_commit_buffer #(
        .ROB_ID_WIDTH(4),
        .ARCH_REG_NUM_WIDTH(5),
        .PHYSICAL_REG_NUM_WIDTH(6)
    ) dut (
        .clk(clk),
        .reset(reset),
        .alloc_valid(alloc_valid),
        .alloc_ready(alloc_ready),
        .alloc_has_write(alloc_has_write),
        .alloc_arch_rd(alloc_arch_rd),
        .alloc_new_phy(alloc_new_phy),
        .alloc_old_phy(alloc_old_phy),
        .alloc_rob_id(alloc_rob_id),
        .complete_valid(complete_valid),
        .complete_rob_id(complete_rob_id),
        .commit_valid(commit_valid),
        .commit_with_write(commit_with_write),
        .commited_wr_register(commited_wr_register),
        .commit_arch_rd(commit_arch_rd),
        .commit_new_phy(commit_new_phy),
        .commit_rob_id(commit_rob_id),
        .rob_count(rob_count),
        .rob_empty(rob_empty),
        .rob_full(rob_full)
    );

    // All stimulus changes and all sampling happen on the falling edge.
    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        alloc_valid    = 1'b0;
        complete_valid = 1'b0;
        reset = 1'b1;
        repeat (2) step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        vectors++; if (alloc_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready: got %0b expected 1", alloc_ready); end
        vectors++; if (rob_empty !== 1'b1) begin miscompares++; $display("FAIL reset_empty: got %0b expected 1", rob_empty); end
        vectors++; if (rob_full !== 1'b0) begin miscompares++; $display("FAIL reset_full: got %0b expected 0", rob_full); end
        vectors++; if (rob_count !== 5'd0) begin miscompares++; $display("FAIL reset_count: got %0d expected 0", rob_count); end
        vectors++; if (commit_valid !== 1'b0) begin miscompares++; $display("FAIL reset_commit_valid: got %0b expected 0", commit_valid); end
        vectors++; if (alloc_rob_id !== 4'd0) begin miscompares++; $display("FAIL reset_alloc_id: got %0d expected 0", alloc_rob_id); end
        $display("test_reset done");
    endtask

    task automatic test_out_of_order();
        do_reset();
        for (int k = 0; k < 3; k++) begin
            alloc_valid = 1'b1; alloc_has_write = 1'b1;
            alloc_arch_rd = 5'(3 + k); alloc_new_phy = 6'(33 + k); alloc_old_phy = 6'(3 + k);
            vectors++; if (alloc_rob_id !== 4'(k)) begin miscompares++; $display("FAIL ooo_alloc_id: got %0d expected %0d", alloc_rob_id, k); end
            step();
        end
        alloc_valid = 1'b0;
        vectors++; if (rob_count !== 5'd3) begin miscompares++; $display("FAIL ooo_count: got %0d expected 3", rob_count); end
        for (int k = 2; k >= 0; k--) begin
            complete_valid = 1'b1; complete_rob_id = 4'(k);
            step();
            vectors++; if (commit_valid !== 1'b0) begin miscompares++; $display("FAIL ooo_early_commit: got %0b expected 0 after complete %0d", commit_valid, k); end
        end
        complete_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            vectors++; if (commit_valid !== 1'b1) begin miscompares++; $display("FAIL ooo_commit_valid: got %0b expected 1 (slot %0d)", commit_valid, k); end
            vectors++; if (commit_rob_id !== 4'(k)) begin miscompares++; $display("FAIL ooo_commit_id: got %0d expected %0d", commit_rob_id, k); end
            vectors++; if (commited_wr_register !== 6'(3 + k)) begin miscompares++; $display("FAIL ooo_old_phy: got %0d expected %0d", commited_wr_register, 3 + k); end
            vectors++; if (commit_new_phy !== 6'(33 + k)) begin miscompares++; $display("FAIL ooo_new_phy: got %0d expected %0d", commit_new_phy, 33 + k); end
            vectors++; if (commit_arch_rd !== 5'(3 + k)) begin miscompares++; $display("FAIL ooo_arch_rd: got %0d expected %0d", commit_arch_rd, 3 + k); end
        end
        step();
        vectors++; if (commit_valid !== 1'b0) begin miscompares++; $display("FAIL ooo_commit_end: got %0b expected 0", commit_valid); end
        vectors++; if (rob_empty !== 1'b1) begin miscompares++; $display("FAIL ooo_empty: got %0b expected 1", rob_empty); end
        $display("test_out_of_order done");
    endtask

    task automatic test_full();
        do_reset();
        for (int k = 0; k < 16; k++) begin
            alloc_valid = 1'b1; alloc_has_write = 1'b1;
            alloc_arch_rd = 5'(k); alloc_new_phy = 6'(32 + k); alloc_old_phy = 6'(k);
            step();
        end
        vectors++; if (rob_full !== 1'b1) begin miscompares++; $display("FAIL full_flag: got %0b expected 1", rob_full); end
        vectors++; if (alloc_ready !== 1'b0) begin miscompares++; $display("FAIL full_ready: got %0b expected 0", alloc_ready); end
        vectors++; if (rob_count !== 5'd16) begin miscompares++; $display("FAIL full_count: got %0d expected 16", rob_count); end
        step();
        vectors++; if (rob_count !== 5'd16) begin miscompares++; $display("FAIL full_ignored_count: got %0d expected 16", rob_count); end
        vectors++; if (alloc_rob_id !== 4'd0) begin miscompares++; $display("FAIL full_ignored_id: got %0d expected 0", alloc_rob_id); end
        complete_valid = 1'b1; complete_rob_id = 4'd0;
        step();
        complete_valid = 1'b0;
        vectors++; if (alloc_ready !== 1'b0) begin miscompares++; $display("FAIL full_no_bypass: got %0b expected 0", alloc_ready); end
        step();
        alloc_valid = 1'b0;
        vectors++; if (commit_valid !== 1'b1 || commit_rob_id !== 4'd0) begin miscompares++; $display("FAIL full_retire: got valid %0b id %0d expected valid 1 id 0", commit_valid, commit_rob_id); end
        vectors++; if (rob_count !== 5'd15) begin miscompares++; $display("FAIL full_after_retire_count: got %0d expected 15", rob_count); end
        vectors++; if (alloc_ready !== 1'b1) begin miscompares++; $display("FAIL full_after_retire_ready: got %0b expected 1", alloc_ready); end
        $display("test_full done");
    endtask

    // Op c allocates at edge c, completes at edge c+1, retires at edge c+2.
    task automatic test_back_to_back();
        do_reset();
        for (int c = 0; c < 24; c++) begin
            alloc_valid = (c < 20); alloc_has_write = 1'b1;
            alloc_arch_rd = 5'(c); alloc_new_phy = 6'(32 + c); alloc_old_phy = 6'(c);
            complete_valid = (c >= 1 && c <= 20); complete_rob_id = 4'((c - 1) % 16);
            if (c < 20) begin
                vectors++; if (alloc_rob_id !== 4'(c % 16)) begin miscompares++; $display("FAIL stream_alloc_id: got %0d expected %0d", alloc_rob_id, c % 16); end
            end
            step();
            if (c >= 2 && c <= 21) begin
                vectors++; if (commit_valid !== 1'b1 || commit_rob_id !== 4'((c - 2) % 16) || commited_wr_register !== 6'(c - 2)) begin
                    miscompares++; $display("FAIL stream_commit: got valid %0b id %0d old %0d expected 1 %0d %0d", commit_valid, commit_rob_id, commited_wr_register, (c - 2) % 16, c - 2);
                end
            end else begin
                vectors++; if (commit_valid !== 1'b0) begin miscompares++; $display("FAIL stream_idle: got %0b expected 0 at cycle %0d", commit_valid, c); end
            end
        end
        complete_valid = 1'b0;
        vectors++; if (rob_empty !== 1'b1) begin miscompares++; $display("FAIL stream_empty: got %0b expected 1", rob_empty); end
        $display("test_back_to_back done");
    endtask

    task automatic test_no_write();
        do_reset();
        alloc_valid = 1'b1; alloc_has_write = 1'b0;
        alloc_arch_rd = 5'd9; alloc_new_phy = 6'd40; alloc_old_phy = 6'd7;
        complete_valid = 1'b1; complete_rob_id = 4'd0;
        step();
        alloc_valid = 1'b0; complete_valid = 1'b0;
        vectors++; if (commit_valid !== 1'b0) begin miscompares++; $display("FAIL nowr_same_cycle_a: got %0b expected 0", commit_valid); end
        step();
        vectors++; if (commit_valid !== 1'b0) begin miscompares++; $display("FAIL nowr_same_cycle_b: got %0b expected 0", commit_valid); end
        complete_valid = 1'b1; complete_rob_id = 4'd0;
        step();
        complete_valid = 1'b0;
        vectors++; if (commit_valid !== 1'b0) begin miscompares++; $display("FAIL nowr_latency: got %0b expected 0", commit_valid); end
        step();
        vectors++; if (commit_valid !== 1'b1) begin miscompares++; $display("FAIL nowr_valid: got %0b expected 1", commit_valid); end
        vectors++; if (commit_with_write !== 1'b0) begin miscompares++; $display("FAIL nowr_with_write: got %0b expected 0", commit_with_write); end
        vectors++; if (commited_wr_register !== 6'd0) begin miscompares++; $display("FAIL nowr_old_phy: got %0d expected 0", commited_wr_register); end
        vectors++; if (commit_new_phy !== 6'd0) begin miscompares++; $display("FAIL nowr_new_phy: got %0d expected 0", commit_new_phy); end
        vectors++; if (commit_arch_rd !== 5'd9) begin miscompares++; $display("FAIL nowr_arch_rd: got %0d expected 9", commit_arch_rd); end
        step();
        vectors++; if (commit_valid !== 1'b0 || commit_arch_rd !== 5'd0) begin miscompares++; $display("FAIL nowr_idle: got valid %0b arch %0d expected 0 0", commit_valid, commit_arch_rd); end
        $display("test_no_write done");
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int k = 0; k < 5; k++) begin
            alloc_valid = 1'b1; alloc_has_write = 1'b1;
            alloc_arch_rd = 5'(k); alloc_new_phy = 6'(40 + k); alloc_old_phy = 6'(10 + k);
            step();
        end
        alloc_valid = 1'b0;
        complete_valid = 1'b1; complete_rob_id = 4'd1;
        step();
        complete_rob_id = 4'd0;
        step();
        complete_valid = 1'b0;
        vectors++; if (rob_count !== 5'd5) begin miscompares++; $display("FAIL mid_count_before: got %0d expected 5", rob_count); end
        reset = 1'b1;
        #1;
        vectors++; if (rob_count !== 5'd0 || rob_empty !== 1'b1) begin miscompares++; $display("FAIL mid_async_clear: got count %0d empty %0b expected 0 1", rob_count, rob_empty); end
        for (int k = 0; k < 2; k++) begin
            step();
            vectors++; if (commit_valid !== 1'b0) begin miscompares++; $display("FAIL mid_no_commit_in_reset: got %0b expected 0", commit_valid); end
        end
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            vectors++; if (commit_valid !== 1'b0) begin miscompares++; $display("FAIL mid_no_commit_after: got %0b expected 0", commit_valid); end
        end
        vectors++; if (rob_count !== 5'd0 || rob_empty !== 1'b1) begin miscompares++; $display("FAIL mid_state: got count %0d empty %0b expected 0 1", rob_count, rob_empty); end
        vectors++; if (alloc_rob_id !== 4'd0) begin miscompares++; $display("FAIL mid_next_id: got %0d expected 0", alloc_rob_id); end
        $display("test_reset_mid done");
    endtask

    initial begin
        reset = 1'b1;
        alloc_valid = 1'b0; alloc_has_write = 1'b0;
        alloc_arch_rd = '0; alloc_new_phy = '0; alloc_old_phy = '0;
        complete_valid = 1'b0; complete_rob_id = '0;
        test_reset();
        test_out_of_order();
        test_full();
        test_back_to_back();
        test_no_write();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
